// File: rtl/mux3_sel_seq.sv
// Purpose : dwell-time round-robin sequencer driving a 3:1 mux select (a, b, c).
// Latency : grant/sel/out_valid update on the same edge that leaves IDLE or ends a slot.
// Backpressure: none; en only gates slot starts, a started slot always runs to completion.
//
// Ports:
//   clk        - single clock, all state on rising edge
//   rst_n      - asynchronous active-low reset
//   en         - run enable, sampled on the IDLE-exit and slot-ending edges
//   req[2:0]   - per-channel request (bit0 = a, bit1 = b, bit2 = c)
//   sel1/sel2  - registered mux select MSB/LSB (a = 00, b = 01, c = 10)
//   grant[2:0] - registered one-hot current channel, same order as req
//   out_valid  - high while a channel is granted
//   slot_done  - high on the last dwell cycle of a slot
//
// Optional feature: define MUX3_SEQ_SKIP_EN to skip channels whose req bit is
// clear; otherwise req is ignored and the rotation is fixed a, b, c, a, ...
module mux3_sel_seq #(
    parameter int unsigned DWELL = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [2:0] req,
    output logic       sel1,
    output logic       sel2,
    output logic [2:0] grant,
    output logic       out_valid,
    output logic       slot_done
);

    // A dwell of 0 is treated as 1 so a slot always lasts at least one cycle.
    localparam logic [3:0] DW_EFF  = (DWELL == 0) ? 4'd1 : 4'(DWELL);
    localparam logic [3:0] DW_LAST = DW_EFF - 4'd1;

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t     state;
    logic [3:0] cnt;
    logic [1:0] last;      // channel index of the last grant, kept across IDLE

    logic [1:0] cand0;
    logic [1:0] cand1;
    logic [1:0] cand2;
    logic [1:0] nxt;
    logic       nxt_ok;
    logic       slot_end;

    function automatic logic [1:0] rot_inc(input logic [1:0] ch);
        return (ch == 2'd2) ? 2'd0 : ch + 2'd1;
    endfunction

    function automatic logic [2:0] onehot(input logic [1:0] ch);
        logic [2:0] oh;
        oh = 3'b000;
        case (ch)
            2'd0:    oh = 3'b001;
            2'd1:    oh = 3'b010;
            2'd2:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

    // Candidates in rotation order, starting just after the last grant.
    always_comb begin
        cand0 = rot_inc(last);
        cand1 = rot_inc(cand0);
        cand2 = rot_inc(cand1);
    end

`ifdef MUX3_SEQ_SKIP_EN
    always_comb begin
        nxt    = cand0;
        nxt_ok = 1'b1;
        if (req[cand0]) begin
            nxt = cand0;
        end else if (req[cand1]) begin
            nxt = cand1;
        end else if (req[cand2]) begin
            nxt = cand2;
        end else begin
            nxt    = cand0;
            nxt_ok = 1'b0;
        end
    end
`else
    // Fixed rotation: req plays no part in eligibility.
    logic unused_req;
    assign unused_req = ^{req, cand1, cand2};

    always_comb begin
        nxt    = cand0;
        nxt_ok = 1'b1;
    end
`endif

    assign slot_end = (state == ACTIVE) && (cnt == DW_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= 4'd0;
            last      <= 2'd2;   // so the first grant after reset is a
            grant     <= 3'b000;
            sel1      <= 1'b0;
            sel2      <= 1'b0;
            out_valid <= 1'b0;
            slot_done <= 1'b0;
        end else if ((state == IDLE) || slot_end) begin
            // req and en are only looked at here: IDLE exit or slot boundary.
            if (en && nxt_ok) begin
                state     <= ACTIVE;
                cnt       <= 4'd0;
                last      <= nxt;
                grant     <= onehot(nxt);
                sel1      <= nxt[1];
                sel2      <= nxt[0];
                out_valid <= 1'b1;
                slot_done <= (DW_LAST == 4'd0);
            end else begin
                state     <= IDLE;
                cnt       <= 4'd0;
                grant     <= 3'b000;
                sel1      <= 1'b0;
                sel2      <= 1'b0;
                out_valid <= 1'b0;
                slot_done <= 1'b0;
            end
        end else begin
            // Mid-slot: hold the channel, advance the dwell count.
            cnt       <= cnt + 4'd1;
            slot_done <= ((cnt + 4'd1) == DW_LAST);
        end
    end

endmodule

// File: doc/mux3_sel_seq.md
MUX3_SEL_SEQ -- requirements
Module: mux3_sel_seq

Interface
REQ-001 The block SHALL have parameter DWELL, default 4: cycles each channel stays selected; legal 1..15; 0 SHALL behave as 1.
REQ-002 Port clk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-003 Port rst_n, input, 1 bit: asynchronous active-low reset.
REQ-004 Port en, input, 1 bit: run enable for the sequencer.
REQ-005 Port req, input, 3 bits: per-channel request; bit0 = a, bit1 = b, bit2 = c.
REQ-006 Port sel1, output, 1 bit: registered MSB of the mux select.
REQ-007 Port sel2, output, 1 bit: registered LSB of the mux select.
REQ-008 Port grant, output, 3 bits: registered one-hot current channel, same bit order as req.
REQ-009 Port out_valid, output, 1 bit: high while a channel is granted.
REQ-010 Port slot_done, output, 1 bit: one-cycle pulse on the last dwell cycle of a slot.

Function
REQ-011 Select encoding SHALL be: channel a = {sel1,sel2} 00, b = 01, c = 10; code 11 SHALL never be driven.
REQ-012 The FSM SHALL have exactly two states, IDLE and ACTIVE.
REQ-013 In IDLE, outputs SHALL be sel = 00, grant = 000, out_valid = 0, slot_done = 0.
REQ-014 IDLE to ACTIVE SHALL occur on the first edge where en = 1 and a next channel exists (REQ-020).
REQ-015 On that edge, grant, sel and out_valid = 1 SHALL update together, giving zero extra latency.
REQ-016 A 4-bit dwell counter SHALL clear on slot entry and increment every ACTIVE cycle.
REQ-017 slot_done SHALL be 1 in the cycle where the counter equals DWELL-1.
REQ-018 On the edge ending a slot, the FSM SHALL either load the next channel (counter to 0) or go to IDLE if en = 0 or no next channel exists.
REQ-019 en deasserted mid-slot SHALL NOT truncate the slot; the current dwell SHALL complete before IDLE.
REQ-020 The next channel SHALL be chosen round-robin starting after the last granted channel, wrapping c to a; the feature in REQ-026 determines eligibility.
REQ-021 A last-granted pointer SHALL persist across IDLE, so resumption continues the rotation rather than restarting at a.
REQ-022 With DWELL = 1, slot_done SHALL stay high continuously and the channel SHALL change every cycle.
REQ-023 A req change mid-slot SHALL NOT affect the current grant; req SHALL be sampled only on the slot-ending edge and the IDLE-exit edge.

Reset
REQ-024 While rst_n = 0, the block SHALL immediately, without waiting for a clock edge, force: state IDLE, sel = 00, grant = 000, out_valid = 0, slot_done = 0, counter 0, last pointer = c (so the first grant is a).
REQ-025 Reset asserted mid-slot SHALL abort the slot; after release, operation SHALL resume per REQ-014 on the first qualifying edge.

Configuration
REQ-026 Macro MUX3_SEQ_SKIP_EN SHALL control channel eligibility:
- defined: only channels with req set are eligible; non-requesting channels are skipped; if none is eligible, the next state is IDLE.
- undefined: req is ignored; rotation is fixed a, b, c, a while en = 1.

Verification
REQ-027 Reset then run: DWELL = 4, en = 1, req = 111 -> sel 00 for 4 cycles, then 01 for 4, then 10 for 4, then 00; slot_done high on the 4th cycle of each slot.
REQ-028 Skip (MUX3_SEQ_SKIP_EN defined): req = 101 -> sel alternates 00 and 10; grant never equals 010. With the macro undefined, the same stimulus -> 01 appears.
REQ-029 Early stop: en dropped in cycle 2 of the b slot -> b held for all 4 cycles, then IDLE (out_valid = 0). Re-enable -> first grant is c.
REQ-030 Mid-slot reset: rst_n pulsed low in cycle 3 of the c slot -> outputs zero with no clock edge; after release, first grant is a.
REQ-031 DWELL = 1, req = 011, macro defined -> grant toggles 001 and 010 every cycle; slot_done constantly 1. Then req = 000 -> IDLE at the next edge.
